display_mux: RTL

//   Time-multiplexed driver for NUM_DIGITOS common-anode 7-segment digits sharing one segment bus.

---
 rtl/display_pkg.sv | 36 +++
 rtl/hex7seg.sv | 17 +
 rtl/display_mux.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
//   Shared definitions for the 7-segment display driver:
//     seg_t        - segment vector {g,f,e,d,c,b,a}, active-low
//     SEG_APAGADO  - all segments off
//     seg_hex()    - hex nibble to active-low segment pattern
// -----------------------------------------------------------------------------
package display_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_APAGADO = 7'h7F;

   function automatic seg_t seg_hex(input logic [3:0] nibble);
      case (nibble)
         4'h0:    seg_hex = 7'h40;
         4'h1:    seg_hex = 7'h79;
         4'h2:    seg_hex = 7'h24;
         4'h3:    seg_hex = 7'h30;
         4'h4:    seg_hex = 7'h19;
         4'h5:    seg_hex = 7'h12;
         4'h6:    seg_hex = 7'h02;
         4'h7:    seg_hex = 7'h78;
         4'h8:    seg_hex = 7'h00;
         4'h9:    seg_hex = 7'h10;
         4'hA:    seg_hex = 7'h08;
         4'hB:    seg_hex = 7'h03;
         4'hC:    seg_hex = 7'h46;
         4'hD:    seg_hex = 7'h21;
         4'hE:    seg_hex = 7'h06;
         4'hF:    seg_hex = 7'h0E;
         default: seg_hex = SEG_APAGADO;
      endcase
   endfunction

endpackage : display_pkg

// File: rtl/hex7seg.sv
// -----------------------------------------------------------------------------
// hex7seg
//   Purely combinational hex nibble to 7-segment decoder (active-low).
//   Ports:
//     nibble_i  in  4  hex digit
//     seg_o     out 7  segments {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module hex7seg
   import display_pkg::*;
(
   input  logic [3:0] nibble_i,
   output seg_t       seg_o
);

   assign seg_o = seg_hex(nibble_i);

endmodule : hex7seg

// File: rtl/display_mux.sv
// -----------------------------------------------------------------------------
// display_mux
//   Time-multiplexed driver for NUM_DIGITOS common-anode 7-segment digits on a
//   shared segment bus. Captures a packed hex word on a load strobe and scans
//   the digits, each held for DIV_REFRESH clocks, with one dark anode cycle at
//   every digit change to avoid ghosting. Supports leading-zero blanking,
//   per-digit decimal point and a global enable that freezes the scan.
//   Ports:
//     clock        in   1              system clock, rising edge
//     reset        in   1              asynchronous, active-low reset
//     carrega      in   1              load strobe for valor/ponto
//     valor        in   4*NUM_DIGITOS  packed hex digits, nibble 0 = digit 0
//     ponto        in   NUM_DIGITOS    decimal point request per digit, 1 = lit
//     apaga_zeros  in   1              blank leading zero digits
//     habilita     in   1              0 = display dark and scan frozen
//     saida        out  7              segments {g..a}, active-low, registered
//     ponto_saida  out  1              decimal point, active-low, registered
//     anodo        out  NUM_DIGITOS    digit select, active-low one-hot
// -----------------------------------------------------------------------------
module display_mux
   import display_pkg::*;
#(
   parameter int NUM_DIGITOS = 4,
   parameter int DIV_REFRESH = 50000
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       carrega,
   input  logic [4*NUM_DIGITOS-1:0]   valor,
   input  logic [NUM_DIGITOS-1:0]     ponto,
   input  logic                       apaga_zeros,
   input  logic                       habilita,
   output logic [6:0]                 saida,
   output logic                       ponto_saida,
   output logic [NUM_DIGITOS-1:0]     anodo
);

   localparam int PS_W  = (DIV_REFRESH > 1) ? $clog2(DIV_REFRESH) : 1;
   localparam int IDX_W = (NUM_DIGITOS > 1) ? $clog2(NUM_DIGITOS) : 1;

   localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(DIV_REFRESH - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITOS - 1);

   if (NUM_DIGITOS < 1 || NUM_DIGITOS > 8 || DIV_REFRESH < 2) begin : g_param_check
      $fatal(1, "display_mux: NUM_DIGITOS must be 1..8 and DIV_REFRESH >= 2");
   end

   logic [4*NUM_DIGITOS-1:0] valor_q, valor_d;
   logic [NUM_DIGITOS-1:0]   ponto_q, ponto_d;
   logic [PS_W-1:0]          prescaler_q, prescaler_d;
   logic [IDX_W-1:0]         indice_q, indice_d;
   seg_t                     saida_q, saida_d;
   logic                     ponto_saida_q, ponto_saida_d;
   logic [NUM_DIGITOS-1:0]   anodo_q, anodo_d;

   logic                     advance;
   logic [3:0]               nibble_sel;
   logic                     dp_sel;
   logic                     blank_sel;
   logic [NUM_DIGITOS-1:0]   anodo_scan;
   logic [NUM_DIGITOS-1:0]   blank_mask;
   logic                     zeros_above;
   seg_t                     seg_dec;

   // Load registers: the strobe is the only capture path.
   always_comb begin
      valor_d = carrega ? valor : valor_q;
      ponto_d = carrega ? ponto : ponto_q;
   end

   // Scan counters advance only while enabled; disabling simply freezes them.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      advance     = 1'b0;
      prescaler_d = prescaler_q;
      indice_d    = indice_q;
      if (habilita) begin
         if (prescaler_q == PS_LAST) begin
            advance     = 1'b1;
            prescaler_d = '0;
            indice_d    = (indice_q == IDX_LAST) ? '0 : indice_q + 1'b1;
         end else begin
            prescaler_d = prescaler_q + 1'b1;
         end
      end
   end

   // A digit is a leading zero when it and every more significant nibble are
   // zero. Digit 0 is never blanked so a zero value still shows "0".
   always_comb begin
      blank_mask  = '0;
      zeros_above = 1'b1;
      for (int i = NUM_DIGITOS - 1; i >= 0; i--) begin
         zeros_above   = zeros_above & (valor_q[4*i +: 4] == 4'h0);
         blank_mask[i] = apaga_zeros & zeros_above & (i != 0);
      end
   end

   // Select the current digit's nibble, point and blanking flag by index.
   always_comb begin
      nibble_sel = '0;
      dp_sel     = 1'b0;
      blank_sel  = 1'b0;
      anodo_scan = '1;
      for (int i = 0; i < NUM_DIGITOS; i++) begin
         if (int'(indice_q) == i) begin
            nibble_sel    = valor_q[4*i +: 4];
            dp_sel        = ponto_q[i];
            blank_sel     = blank_mask[i];
            anodo_scan[i] = 1'b0;
         end
      end
   end

   hex7seg u_hex7seg (
      .nibble_i (nibble_sel),
      .seg_o    (seg_dec)
   );

   // Output stage. On the advancing edge the anodes go dark for one cycle
   // while the segments still reflect the outgoing digit; the next edge then
   // drives the new digit's segments and anode together.
   always_comb begin
      saida_d       = SEG_APAGADO;
      ponto_saida_d = 1'b1;
      anodo_d       = '1;
      if (habilita) begin
         saida_d       = blank_sel ? SEG_APAGADO : seg_dec;
         ponto_saida_d = ~dp_sel;
         anodo_d       = advance ? '1 : anodo_scan;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valor_q       <= '0;
         ponto_q       <= '0;
         prescaler_q   <= '0;
         indice_q      <= '0;
         saida_q       <= SEG_APAGADO;
         ponto_saida_q <= 1'b1;
         anodo_q       <= '1;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         valor_q       <= valor_d;
         ponto_q       <= ponto_d;
         prescaler_q   <= prescaler_d;
         indice_q      <= indice_d;
         saida_q       <= saida_d;
         ponto_saida_q <= ponto_saida_d;
         anodo_q       <= anodo_d;
      end
   end

   assign saida       = saida_q;
   assign ponto_saida = ponto_saida_q;
   assign anodo       = anodo_q;

endmodule : display_mux
